// File: rtl/game_phase_ctrl_pkg.sv
// rtl/game_phase_ctrl_pkg.sv - shared types and constants for the game phase sequencer
// Contents:
//   phase_e     : IDLE=0, READY=1, PLAY=2, OVER=3
//   disp_t      : one full board display word (digit select, two segment buses, LEDs)
//   cnt_w()     : counter width helper that never returns zero
package game_pkg;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_READY = 2'd1,
      PH_PLAY  = 2'd2,
      PH_OVER  = 2'd3
   } phase_e;

   typedef struct packed {
      logic [7:0] dig;
      logic [7:0] seg1;
      logic [7:0] seg2;
      logic [7:0] led;
   } disp_t;

   localparam logic [7:0] LED_ALL_ON     = 8'hFF;
   localparam logic [7:0] LED_ALL_OFF    = 8'h00;
   localparam logic [7:0] DIG_OFF        = 8'h00;
   localparam int         CLK_PER_MS_DEF = 100000;
   localparam int         MS_PER_SEC     = 1000;
   localparam int         MS_PER_HALF    = 500;

   // Width for a counter whose largest value is n-1; a 1-wide counter is kept
   // for n<=1 so zero-width vectors never appear.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/game_phase_ctrl_if.sv
// rtl/game_phase_ctrl_if.sv - board/phase-block signal bundle of the phase sequencer
// Modports:
//   master : used by game_phase_ctrl (buttons and phase-block sources in, board pins out)
//   slave  : used by the surrounding board logic / bench (the reverse directions)
interface game_phase_ctrl_if;
   import game_pkg::*;

   logic       start_btn;
   logic       stop_btn;
   logic       ready_done;
   logic [7:0] rdy_dig, rdy_seg1, rdy_seg2, rdy_led;
   logic [7:0] ply_dig, ply_seg1, ply_seg2, ply_led;

   logic       start_game;
   logic       play_en;
   logic       sub_rst;
   logic [1:0] phase;
   logic [5:0] time_left;
   logic       err_flag;
   logic [7:0] dig_display, seg_code_1, seg_code_2, state_led_show;

   modport master (
      input  start_btn, stop_btn, ready_done,
      input  rdy_dig, rdy_seg1, rdy_seg2, rdy_led,
      input  ply_dig, ply_seg1, ply_seg2, ply_led,
      output start_game, play_en, sub_rst, phase, time_left, err_flag,
      output dig_display, seg_code_1, seg_code_2, state_led_show
   );

   modport slave (
      output start_btn, stop_btn, ready_done,
      output rdy_dig, rdy_seg1, rdy_seg2, rdy_led,
      output ply_dig, ply_seg1, ply_seg2, ply_led,
      input  start_game, play_en, sub_rst, phase, time_left, err_flag,
      input  dig_display, seg_code_1, seg_code_2, state_led_show
   );

endinterface

// File: rtl/game_phase_ctrl_tick_gen.sv
// rtl/game_phase_ctrl_tick_gen.sv - millisecond, half-second and second tick generator
// Ports:
//   clk, rst   : board clock, synchronous active-high reset
//   clr        : restart all intervals from zero (phase change)
//   ms_tick    : 1-cycle pulse every CLK_PER_MS cycles
//   half_tick  : 1-cycle pulse on every 500th ms_tick
//   sec_tick   : 1-cycle pulse on every 1000th ms_tick
module game_tick_gen
   import game_pkg::*;
#(
   parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic ms_tick,
   output logic sec_tick,
   output logic half_tick
);

   localparam int CYC_W = cnt_w(CLK_PER_MS);
   localparam int MS_W  = cnt_w(MS_PER_SEC);

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [MS_W-1:0]  msec_q, msec_d;

   always_comb begin
      ms_tick   = (cyc_q == CYC_W'(CLK_PER_MS - 1));
      sec_tick  = ms_tick && (msec_q == MS_W'(MS_PER_SEC - 1));
      half_tick = ms_tick && ((msec_q == MS_W'(MS_PER_HALF - 1)) || sec_tick);
      cyc_d     = ms_tick ? '0 : cyc_q + CYC_W'(1);
      msec_d    = msec_q;
      if (ms_tick) begin
         msec_d = sec_tick ? '0 : msec_q + MS_W'(1);
      end
      if (clr) begin
         cyc_d  = '0;
         msec_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         msec_q <= '0;
      end else begin
         cyc_q  <= cyc_d;
         msec_q <= msec_d;
      end
   end

endmodule

// File: rtl/game_phase_ctrl.sv
// rtl/game_phase_ctrl.sv - IDLE/READY/PLAY/OVER sequencer and board display arbiter
// Ports:
//   clk, rst : board clock, synchronous active-high reset
//   bus      : game_phase_ctrl_if.master - buttons, ready_done, phase-block display
//              sources in; enables, sub_rst, phase, time_left, err_flag and the
//              arbitrated display pins out
module game_phase_ctrl
   import game_pkg::*;
#(
   parameter int CLK_PER_MS  = CLK_PER_MS_DEF,
   parameter int PLAY_SEC    = 30,
   parameter int OVER_SEC    = 5,
   parameter int READY_TO_MS = 5000
) (
   input  logic                  clk,
   input  logic                  rst,
   game_phase_ctrl_if.master     bus
);

   localparam int RDY_W = cnt_w(READY_TO_MS);
   localparam int OVR_W = cnt_w(OVER_SEC);

   phase_e           state_q, state_d;
   logic             start_cur_q, start_prev_q, stop_cur_q, stop_prev_q;
   logic             start_ev, stop_ev;
   logic [5:0]       time_left_q, time_left_d;
   logic             err_q, err_d;
   logic             sub_rst_q, sub_rst_d;
   disp_t            disp_q, disp_d;
   logic [7:0]       blink_q, blink_d;
   logic [RDY_W-1:0] rdy_ms_q, rdy_ms_d;
   logic [OVR_W-1:0] over_sec_q, over_sec_d;
   logic             phase_chg;
   logic             ms_tick, sec_tick, half_tick;

   assign start_ev  = start_cur_q & ~start_prev_q;
   assign stop_ev   = stop_cur_q & ~stop_prev_q;
   assign phase_chg = (state_d != state_q);

   // Intervals restart on every phase change so each phase gets full periods.
   game_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .clr       (phase_chg),
      .ms_tick   (ms_tick),
      .sec_tick  (sec_tick),
      .half_tick (half_tick)
   );

   always_comb begin
      state_d     = state_q;
      time_left_d = time_left_q;
      err_d       = err_q;
      sub_rst_d   = 1'b0;
      rdy_ms_d    = rdy_ms_q;
      over_sec_d  = over_sec_q;
      blink_d     = blink_q;
      disp_d      = '{dig: DIG_OFF, seg1: DIG_OFF, seg2: DIG_OFF, led: LED_ALL_OFF};

      unique case (state_q)
         PH_IDLE: begin
            if (start_ev) begin
               state_d = PH_READY;
               err_d   = 1'b0;
            end
         end
         PH_READY: begin
            disp_d = {bus.rdy_dig, bus.rdy_seg1, bus.rdy_seg2, bus.rdy_led};
            if (ms_tick) rdy_ms_d = rdy_ms_q + RDY_W'(1);
            // ready_done has priority over a watchdog expiry in the same cycle
            if (bus.ready_done) begin
               state_d     = PH_PLAY;
               time_left_d = 6'(PLAY_SEC);
            end else if (ms_tick && (rdy_ms_q == RDY_W'(READY_TO_MS - 1))) begin
               state_d   = PH_IDLE;
               err_d     = 1'b1;
               sub_rst_d = 1'b1;
            end
         end
         PH_PLAY: begin
            disp_d = {bus.ply_dig, bus.ply_seg1, bus.ply_seg2, bus.ply_led};
            if (sec_tick && (time_left_q != 6'd0)) begin
               time_left_d = time_left_q - 6'd1;
               if (time_left_q == 6'd1) state_d = PH_OVER;
            end
            if (stop_ev) state_d = PH_OVER;
         end
         PH_OVER: begin
            disp_d.led = blink_q;
            if (half_tick) blink_d = ~blink_q;
            if (sec_tick) begin
               over_sec_d = over_sec_q + OVR_W'(1);
               if (over_sec_q == OVR_W'(OVER_SEC - 1)) begin
                  state_d     = PH_IDLE;
                  sub_rst_d   = 1'b1;
                  time_left_d = 6'd0;
               end
            end
         end
      endcase

      if (state_d != state_q) begin
         rdy_ms_d   = '0;
         over_sec_d = '0;
         if (state_d == PH_OVER) blink_d = LED_ALL_ON;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= PH_IDLE;
         start_cur_q  <= 1'b0;
         start_prev_q <= 1'b0;
         stop_cur_q   <= 1'b0;
         stop_prev_q  <= 1'b0;
         time_left_q  <= 6'd0;
         err_q        <= 1'b0;
         sub_rst_q    <= 1'b0;
         disp_q       <= '0;
         blink_q      <= LED_ALL_OFF;
         rdy_ms_q     <= '0;
         over_sec_q   <= '0;
      end else begin
         state_q      <= state_d;
         start_cur_q  <= bus.start_btn;
         start_prev_q <= start_cur_q;
         stop_cur_q   <= bus.stop_btn;
         stop_prev_q  <= stop_cur_q;
         time_left_q  <= time_left_d;
         err_q        <= err_d;
         sub_rst_q    <= sub_rst_d;
         disp_q       <= disp_d;
         blink_q      <= blink_d;
         rdy_ms_q     <= rdy_ms_d;
         over_sec_q   <= over_sec_d;
      end
   end

   // Display is selected from the registered phase, so a phase change reaches
   // the pins one cycle later and never mixes two sources in one cycle.
   assign bus.phase          = state_q;
   assign bus.start_game     = (state_q == PH_READY);
   assign bus.play_en        = (state_q == PH_PLAY);
   assign bus.sub_rst        = rst | sub_rst_q;
   assign bus.time_left      = time_left_q;
   assign bus.err_flag       = err_q;
   assign bus.dig_display    = disp_q.dig;
   assign bus.seg_code_1     = disp_q.seg1;
   assign bus.seg_code_2     = disp_q.seg2;
   assign bus.state_led_show = disp_q.led;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// tb/tb_game_phase_ctrl.sv - self-checking bench for game_phase_ctrl
module tb_game_phase_ctrl;
   import game_pkg::*;

   localparam int CPM      = 4;
   localparam int PSEC     = 3;
   localparam int OSEC     = 2;
   localparam int RTO      = 5000;
   localparam int SEC_CYC  = 1000 * CPM;
   localparam int HALF_CYC = 500 * CPM;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   game_phase_ctrl_if bus ();

   game_phase_ctrl #(
      .CLK_PER_MS (CPM),
      .PLAY_SEC   (PSEC),
      .OVER_SEC   (OSEC),
      .READY_TO_MS(RTO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Phase-level reference: position inside a phase is a plain cycle count m_t,
   // and every timer is derived from it arithmetically.
   int         m_ph = 0, m_t = 0, m_tl = 0;
   bit         m_err = 0, m_sub = 0, armed = 0;
   bit         m_scur = 0, m_sprev = 0, m_pcur = 0, m_pprev = 0;
   logic [7:0] m_dig = 0, m_s1 = 0, m_s2 = 0, m_led = 0;

   always @(posedge clk) begin : model
      int nph, ntl;
      bit nerr, nsub, sev, pev;
      logic [7:0] nd, n1, n2, nl;
      nph = m_ph; ntl = m_tl; nerr = m_err; nsub = 1'b0;
      sev = m_scur && !m_sprev;
      pev = m_pcur && !m_pprev;
      nd = 8'h00; n1 = 8'h00; n2 = 8'h00; nl = 8'h00;
      if (m_ph == 1) begin nd = bus.rdy_dig; n1 = bus.rdy_seg1; n2 = bus.rdy_seg2; nl = bus.rdy_led; end
      if (m_ph == 2) begin nd = bus.ply_dig; n1 = bus.ply_seg1; n2 = bus.ply_seg2; nl = bus.ply_led; end
      if (m_ph == 3) nl = (((m_t / HALF_CYC) % 2) == 0) ? LED_ALL_ON : LED_ALL_OFF;
      case (m_ph)
         0: if (sev) begin nph = 1; nerr = 1'b0; end
         1: begin
            if (bus.ready_done) begin nph = 2; ntl = PSEC; end
            else if (m_t + 1 == RTO * CPM) begin nph = 0; nerr = 1'b1; nsub = 1'b1; end
         end
         2: begin
            if (((m_t + 1) % SEC_CYC == 0) && m_tl > 0) ntl = m_tl - 1;
            if (ntl == 0 || pev) nph = 3;
         end
         default: if (m_t + 1 == OSEC * SEC_CYC) begin nph = 0; nsub = 1'b1; ntl = 0; end
      endcase
      if (rst) begin
         nph = 0; ntl = 0; nerr = 1'b0; nsub = 1'b0;
         nd = 8'h00; n1 = 8'h00; n2 = 8'h00; nl = 8'h00;
      end
      m_t     <= (rst || nph != m_ph) ? 0 : m_t + 1;
      m_ph    <= nph;
      m_tl    <= ntl;
      m_err   <= nerr;
      m_sub   <= nsub;
      m_dig   <= nd; m_s1 <= n1; m_s2 <= n2; m_led <= nl;
      m_scur  <= rst ? 1'b0 : bus.start_btn;
      m_sprev <= rst ? 1'b0 : m_scur;
      m_pcur  <= rst ? 1'b0 : bus.stop_btn;
      m_pprev <= rst ? 1'b0 : m_pcur;
      armed   <= 1'b1;
   end

   always @(negedge clk) begin : compare
      logic [43:0] act, exp;
      if (armed) begin
         act = {bus.phase, bus.start_game, bus.play_en, bus.sub_rst, bus.time_left, bus.err_flag,
                bus.dig_display, bus.seg_code_1, bus.seg_code_2, bus.state_led_show};
         exp = {2'(m_ph), (m_ph == 1), (m_ph == 2), (rst | m_sub), 6'(m_tl), m_err,
                m_dig, m_s1, m_s2, m_led};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL outputs: got %h expected %h at %0t", act, exp, $time);
         end
      end
   end

   initial begin : sources
      bus.rdy_dig = 8'h00; bus.rdy_seg1 = 8'h00; bus.rdy_seg2 = 8'h00; bus.rdy_led = 8'h00;
      bus.ply_dig = 8'h00; bus.ply_seg1 = 8'h00; bus.ply_seg2 = 8'h00; bus.ply_led = 8'h00;
      forever begin
         @(negedge clk);
         #1;
         bus.rdy_dig = 8'($urandom); bus.rdy_seg1 = 8'($urandom);
         bus.rdy_seg2 = 8'($urandom); bus.rdy_led = 8'($urandom);
         bus.ply_dig = 8'($urandom); bus.ply_seg1 = 8'($urandom);
         bus.ply_seg2 = 8'($urandom); bus.ply_led = 8'($urandom);
      end
   end

   task automatic wait_phase(input int ph, input int lim, output int n);
      n = 0;
      while (int'(bus.phase) != ph && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n, ntr;
      logic [1:0] prev;
      bus.start_btn = 1'b0; bus.stop_btn = 1'b0; bus.ready_done = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sub_rst", bus.sub_rst, 1);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_phase", bus.phase, 0);
      chk("idle_time_left", bus.time_left, 0);
      chk("idle_dig", bus.dig_display, 0);
      chk("idle_sub_rst", bus.sub_rst, 0);

      // start held high: one transition, enable latency, display mirror latency
      #1 bus.start_btn = 1'b1;
      ntr = 0; prev = bus.phase;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (bus.phase != prev) ntr++;
         prev = bus.phase;
         if (i == 1) chk("start_game_lat1", bus.start_game, 0);
         if (i == 2) chk("start_game_lat2", bus.start_game, 1);
         if (i == 3) chk("dig_mirror", bus.dig_display, bus.rdy_dig);
      end
      chk("start_one_transition", ntr, 1);
      chk("ready_phase", bus.phase, 1);
      #1 bus.start_btn = 1'b0; bus.ready_done = 1'b1;
      @(negedge clk);
      chk("play_phase", bus.phase, 2);
      chk("play_time_load", bus.time_left, PSEC);
      chk("play_en", bus.play_en, 1);
      #1 bus.ready_done = 1'b0;
      wait_phase(3, 20000, n);
      chk("play_len", n, 3 * SEC_CYC);
      chk("over_time_left", bus.time_left, 0);

      // game-over blink and duration
      n = 0;
      @(negedge clk);
      while (bus.state_led_show == LED_ALL_ON && n < 3000) begin
         n++;
         @(negedge clk);
      end
      chk("led_on_len", n, 2000);
      chk("led_off", bus.state_led_show, 0);
      wait_phase(0, 8000, n);
      chk("over_len", n + 2001, 8000);
      chk("over_sub_rst_on", bus.sub_rst, 1);
      @(negedge clk);
      chk("over_sub_rst_off", bus.sub_rst, 0);

      // stop after 1 s of play
      #1 bus.start_btn = 1'b1;
      wait_phase(1, 10, n);
      chk("s2_ready", bus.phase, 1);
      #1 bus.start_btn = 1'b0; bus.ready_done = 1'b1;
      @(negedge clk);
      chk("s2_play", bus.phase, 2);
      #1 bus.ready_done = 1'b0;
      repeat (SEC_CYC) @(negedge clk);
      chk("tl_after_1s", bus.time_left, 2);
      #1 bus.stop_btn = 1'b1;
      @(negedge clk);
      chk("stop_lat1", bus.phase, 2);
      @(negedge clk);
      chk("stop_lat2", bus.phase, 3);
      chk("stop_freeze", bus.time_left, 2);
      #1 bus.stop_btn = 1'b0;
      wait_phase(0, 9000, n);
      chk("s2_over_len", n, 8000);

      // READY watchdog
      #1 bus.start_btn = 1'b1;
      wait_phase(1, 10, n);
      #1 bus.start_btn = 1'b0;
      wait_phase(0, 25000, n);
      chk("rdy_timeout_len", n, 20000);
      chk("rdy_timeout_err", bus.err_flag, 1);
      chk("rdy_timeout_sub_rst", bus.sub_rst, 1);
      @(negedge clk);
      chk("rdy_sub_rst_off", bus.sub_rst, 0);
      chk("err_held", bus.err_flag, 1);
      #1 bus.start_btn = 1'b1;
      wait_phase(1, 10, n);
      chk("err_clear", bus.err_flag, 0);

      // reset mid-play
      #1 bus.start_btn = 1'b0; bus.ready_done = 1'b1;
      @(negedge clk);
      chk("s4_play", bus.phase, 2);
      #1 bus.ready_done = 1'b0;
      repeat (100) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_phase", bus.phase, 0);
      chk("rst_time_left", bus.time_left, 0);
      chk("rst_disp", {bus.dig_display, bus.seg_code_1, bus.seg_code_2, bus.state_led_show}, 0);
      chk("rst_sub_rst_mid", bus.sub_rst, 1);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_sub_rst_after", bus.sub_rst, 0);

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 20000; i++) begin
         #1;
         if ($urandom_range(0, 99) == 0) bus.start_btn = ~bus.start_btn;
         if ($urandom_range(0, 299) == 0) bus.stop_btn = ~bus.stop_btn;
         if ($urandom_range(0, 49) == 0) bus.ready_done = ~bus.ready_done;
         rst = ($urandom_range(0, 7999) == 0);
         @(negedge clk);
      end
      #1 rst = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/game_phase_ctrl.md
Name: game_phase_ctrl

Overview:
- Top-level phase sequencer for the whack-a-mole game: IDLE -> READY -> PLAY -> OVER -> IDLE.
- Enables the ready-prompt block and the play block in turn.
- Owns the play countdown and the game-over blink.
- Arbitrates the shared 8-digit display, the two segment buses and the 8 state LEDs between phase blocks, so only one source drives the board pins at a time.

Parameters:
- CLK_PER_MS, 100000: clk cycles per 1 ms tick (100 MHz board clock).
- PLAY_SEC, 30: play-phase duration in seconds, 1..63.
- OVER_SEC, 5: game-over display duration in seconds, 1..15.
- READY_TO_MS, 5000: READY watchdog in ms; must exceed the ready block's 3 s prompt.

Ports:
- clk  in  1  board clock
- rst  in  1  synchronous active-high reset
- start_btn  in  1  debounced start key, level
- stop_btn  in  1  debounced abort key, level
- ready_done  in  1  ready block finished; sticky until that block is reset
- rdy_dig, rdy_seg1, rdy_seg2, rdy_led  in  8 each  ready block display sources
- ply_dig, ply_seg1, ply_seg2, ply_led  in  8 each  play block display sources
- start_game  out  1  ready block enable; high only in READY
- play_en  out  1  play block enable; high only in PLAY
- sub_rst  out  1  reset to phase blocks
- phase  out  2  current state: IDLE=0, READY=1, PLAY=2, OVER=3
- time_left  out  6  remaining play seconds
- err_flag  out  1  READY watchdog expired
- dig_display, seg_code_1, seg_code_2, state_led_show  out  8 each  arbitrated board outputs

Behaviour:
- Reset (rst sampled high at a clk edge):
  - phase=IDLE; start_game=0; play_en=0; time_left=0; err_flag=0.
  - All display outputs 0.
  - sub_rst=1 for every cycle rst is high.
  - All counters 0; edge-detect history registers 0.
- Edge detect: start_btn and stop_btn are registered once. An edge is cur=1 and prev=1'b0 (prev is the registered copy). A level held high produces one event only.
- ms_tick: 1-cycle pulse every CLK_PER_MS cycles. The ms counter and ms-in-second counter clear on every phase change, so each phase starts with a full interval.
- IDLE:
  - start edge -> READY on the next edge.
  - err_flag clears on that transition.
  - All display outputs 0.
- READY:
  - start_game=1.
  - Outputs mirror rdy_* registered (1-cycle latency).
  - ready_done=1 -> PLAY next cycle, with time_left loaded to PLAY_SEC in the same cycle.
  - READY_TO_MS ms elapse without ready_done -> IDLE, err_flag=1, sub_rst pulse of 1 cycle.
  - If ready_done and the timeout occur in the same cycle, ready_done wins.
- PLAY:
  - play_en=1; outputs mirror ply_* registered.
  - Each 1000th ms_tick decrements time_left.
  - Decrement from 1 -> OVER next cycle; time_left=0 in OVER.
  - stop edge -> OVER next cycle; time_left freezes at its current value.
  - If a stop edge and the final decrement coincide, go to OVER with time_left=0.
- OVER:
  - dig_display=0; seg buses=0.
  - state_led_show starts at 8'hFF on entry and toggles 8'hFF/8'h00 every 500 ms.
  - After OVER_SEC seconds -> IDLE with a 1-cycle sub_rst pulse; time_left=0.
- start edges outside IDLE and stop edges outside PLAY are ignored; no queuing.
- sub_rst is otherwise 0 and is registered.
- Only one source ever reaches the outputs. On each phase change the outputs switch on the following cycle; no mixed-source cycle.
- Width rules:
  - Counters sized by $clog2 of their terminal value.
  - time_left never underflows.
  - The ms-in-second counter wraps at 999 -> 0.
- rst mid-phase: immediate return to IDLE on the next edge; no pending transition survives.

Decomposition:
- Shared package game_pkg:
  - phase encodings PH_IDLE/PH_READY/PH_PLAY/PH_OVER;
  - LED_ALL_ON = 8'hFF and LED_ALL_OFF = 8'h00;
  - DIG_OFF = 8'h00;
  - default clock constant 100000.
- Sub-module game_tick_gen(clk, rst, clr, ms_tick, sec_tick, half_tick), parameterised by CLK_PER_MS.
  - clr is driven high on phase change.
  - Reused later by the play block.

Test Plan (CLK_PER_MS=4, PLAY_SEC=3, OVER_SEC=2, READY_TO_MS=5000):
- Reset then start_btn held high for 50 cycles -> exactly one IDLE->READY transition; start_game=1 two cycles after the rising edge; dig_display equals rdy_dig one cycle later.
- In READY, raise ready_done -> phase=2 next cycle; time_left=3; play_en=1; time_left reaches 0 and phase=3 exactly 3*4000 cycles after PLAY entry.
- In PLAY after 1 s, pulse stop_btn -> phase=3 two cycles after the edge; time_left frozen at 2.
- OVER -> state_led_show 8'hFF for 2000 cycles, then 8'h00; after 8000 cycles phase=0 and sub_rst high for exactly one cycle.
- Hold ready_done=0 in READY -> after 20000 cycles phase=0, err_flag=1, sub_rst one cycle; next start edge clears err_flag.
- Assert rst for one cycle mid-PLAY -> next cycle: phase=0, time_left=0, all display outputs 0, sub_rst was 1 during rst.
